// File: rtl/ya_fifo_reader.sv
// Read-side adapter: drains a non-FWFT FIFO into a valid/ready stream through a 2-entry skid buffer.
// Optional same-cycle bypass of the arriving FIFO word is enabled by defining YA_FIFO_READER_BYPASS_EN.
module ya_fifo_reader #(
    parameter int WORD_SIZE = 8
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    output logic                 o_re,
    input  logic                 i_is_not_empty,
    input  logic [WORD_SIZE-1:0] i_data,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [WORD_SIZE-1:0] o_data,
    output logic [1:0]           o_level
);

    logic [WORD_SIZE-1:0] buf_q [0:1];
    logic                 rd_ptr;
    logic                 wr_ptr;
    logic                 inflight;
    logic [1:0]           cnt;

    logic       pop;
    logic       push;
    logic       pop_buf;
    logic       buf_valid;
    logic       has_room;
    logic [1:0] occupancy;

    // Words already held plus the one still coming back from the FIFO.
    assign occupancy = cnt + {1'b0, inflight};
    assign has_room  = (occupancy < 2'd2);
    assign buf_valid = (cnt != 2'd0);

`ifdef YA_FIFO_READER_BYPASS_EN
    logic bypass;

    assign bypass  = inflight & ~buf_valid;
    assign o_valid = i_reset & (buf_valid | bypass);
    assign o_data  = !i_reset ? '0 : (bypass ? i_data : buf_q[rd_ptr]);
    // A bypassed word consumed on arrival never lands in the buffer.
    assign push    = inflight & ~(bypass & pop);
`else
    assign o_valid = i_reset & buf_valid;
    assign o_data  = i_reset ? buf_q[rd_ptr] : '0;
    assign push    = inflight;
`endif

    assign pop     = o_valid & i_ready;
    assign pop_buf = pop & buf_valid;
    assign o_re    = i_reset & i_is_not_empty & (has_room | pop);
    assign o_level = i_reset ? cnt : 2'd0;

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            cnt      <= 2'd0;
            inflight <= 1'b0;
            rd_ptr   <= 1'b0;
            wr_ptr   <= 1'b0;
            buf_q[0] <= '0;
            buf_q[1] <= '0;
        end else begin
            inflight <= o_re;
            if (push) begin
                buf_q[wr_ptr] <= i_data;
                wr_ptr        <= ~wr_ptr;
            end
            if (pop_buf) begin
                rd_ptr <= ~rd_ptr;
            end
            cnt <= cnt + {1'b0, push} - {1'b0, pop_buf};
        end
    end

endmodule

// File: tb/tb_ya_fifo_reader.sv
// Bench for ya_fifo_reader: behavioural non-FWFT FIFO upstream, scoreboard of write order downstream.
module tb_ya_fifo_reader;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         dut_re;
    logic         not_empty;
    logic         valid;
    logic         ready;
    logic [W-1:0] fifo_dout = '0;
    logic [W-1:0] odata;
    logic [1:0]   level;

    logic         wr_en;
    logic [W-1:0] wr_data;
    logic [W-1:0] mem [0:4095];
    logic [11:0]  wp;
    logic [11:0]  rp;

    always #5 clk = ~clk;

    // Standard FIFO: read data appears the cycle after i_re.
    assign not_empty = (wp != rp);
    always @(posedge clk) begin
        if (!rst_n) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (wr_en) begin
                mem[wp] <= wr_data;
                wp      <= wp + 12'd1;
            end
            if (dut_re) begin
                fifo_dout <= mem[rp];
                rp        <= rp + 12'd1;
            end
        end
    end

    ya_fifo_reader #(.WORD_SIZE(W)) dut (
        .i_clk          (clk),
        .i_reset        (rst_n),
        .o_re           (dut_re),
        .i_is_not_empty (not_empty),
        .i_data         (fifo_dout),
        .o_valid        (valid),
        .i_ready        (ready),
        .o_data         (odata),
        .o_level        (level)
    );

    int           tests = 0;
    int           fails = 0;
    int           pops = 0;
    int           re_pulses = 0;
    logic [W-1:0] exp_q [$];
    logic [W-1:0] last_pop;
    logic         s_valid, s_re, s_ne;
    logic [W-1:0] s_data;
    logic [1:0]   s_level;
    logic         prev_hold = 1'b0;
    logic [W-1:0] prev_data;

    typedef struct {
        logic         wr;
        logic [W-1:0] d;
        logic         rdy;
        logic         e_re;
        logic         e_valid;
        logic         chk_d;
        logic [W-1:0] e_data;
        logic [1:0]   e_level;
    } vec_t;
    vec_t tbl [5];

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Sample the current cycle just after inputs settle, score it, move to the next cycle.
    task automatic tick();
        logic [W-1:0] e;
        #1;
        s_valid = valid;
        s_re    = dut_re;
        s_ne    = not_empty;
        s_data  = odata;
        s_level = level;
        if (s_re) re_pulses++;
        if (rst_n) begin
            check("level_max", int'(s_level <= 2'd2), 1);
            if (s_re) check("re_while_empty", int'(s_ne), 1);
            if (prev_hold) begin
                check("hold_valid", int'(s_valid), 1);
                check("hold_data", int'(s_data), int'(prev_data));
            end
            if (s_valid && ready) begin
                check("pop_has_word", exp_q.size() > 0 ? 1 : 0, 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("pop_data", int'(s_data), int'(e));
                end
                last_pop = s_data;
                pops++;
            end
            prev_hold = s_valid && !ready;
            prev_data = s_data;
        end else begin
            prev_hold = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic put(input logic [W-1:0] d);
        wr_en   = 1'b1;
        wr_data = d;
        exp_q.push_back(d);
        tick();
        wr_en = 1'b0;
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        wr_en = 1'b0;
        for (int i = 0; i < n; i++) begin
            tick();
            check("rst_valid", int'(s_valid), 0);
            check("rst_re", int'(s_re), 0);
            check("rst_level", int'(s_level), 0);
            check("rst_data", int'(s_data), 0);
        end
        exp_q.delete();
        prev_hold = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic drain(input int limit);
        int n = 0;
        ready = 1'b1;
        while (exp_q.size() != 0 && n < limit) begin
            tick();
            n++;
        end
        check("drain_left", exp_q.size(), 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int written;
        int cyc;
        rst_n   = 1'b0;
        ready   = 1'b0;
        wr_en   = 1'b0;
        wr_data = '0;
        @(negedge clk);
        do_reset(2);

        // Single word through an idle reader, cycle by cycle.
`ifdef YA_FIFO_READER_BYPASS_EN
        tbl[0] = '{1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 2'd0};
        tbl[1] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 2'd0};
        tbl[2] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'hA5, 2'd0};
        tbl[3] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 2'd0};
        tbl[4] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 2'd0};
`else
        tbl[0] = '{1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 2'd0};
        tbl[1] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 2'd0};
        tbl[2] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 2'd0};
        tbl[3] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'hA5, 2'd1};
        tbl[4] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 2'd0};
`endif
        re_pulses = 0;
        for (int i = 0; i < 5; i++) begin
            wr_en   = tbl[i].wr;
            wr_data = tbl[i].d;
            ready   = tbl[i].rdy;
            if (tbl[i].wr) exp_q.push_back(tbl[i].d);
            tick();
            wr_en = 1'b0;
            check($sformatf("single_re[%0d]", i), int'(s_re), int'(tbl[i].e_re));
            check($sformatf("single_valid[%0d]", i), int'(s_valid), int'(tbl[i].e_valid));
            check($sformatf("single_level[%0d]", i), int'(s_level), int'(tbl[i].e_level));
            if (tbl[i].chk_d) check($sformatf("single_data[%0d]", i), int'(s_data), int'(tbl[i].e_data));
        end
        check("single_re_pulses", re_pulses, 1);

        // Streaming 64 words back to back.
        ready = 1'b0;
        for (int i = 0; i < 64; i++) put(W'(i));
        ready = 1'b1;
        for (int i = 0; i <= 64; i++) begin
            tick();
            if (i < 64) begin
                check("stream_valid", int'(s_valid), 1);
                check("stream_data", int'(s_data), i);
            end else begin
                check("stream_end_valid", int'(s_valid), 0);
            end
        end

        // Backpressure: at most two reads outstanding while the consumer stalls.
        ready     = 1'b0;
        re_pulses = 0;
        pops      = 0;
        for (int i = 0; i < 8; i++) put(W'(8'h80 + i));
        for (int i = 0; i < 10; i++) begin
            tick();
            check("bp_valid", int'(s_valid), 1);
            check("bp_data", int'(s_data), 8'h80);
        end
        check("bp_re_pulses", re_pulses, 2);
        check("bp_level", int'(s_level), 2);
        drain(100);
        check("bp_pops", pops, 8);
        tick();
        check("bp_empty_valid", int'(s_valid), 0);

        // Random backpressure and bursty writes.
        pops    = 0;
        written = 0;
        cyc     = 0;
        while ((written < 1000 || exp_q.size() != 0) && cyc < 20000) begin
            ready = 1'($urandom_range(0, 1));
            if (written < 1000 && $urandom_range(0, 3) != 0) begin
                wr_en   = 1'b1;
                wr_data = W'($urandom);
                exp_q.push_back(wr_data);
                written++;
            end else begin
                wr_en = 1'b0;
            end
            tick();
            wr_en = 1'b0;
            cyc++;
        end
        check("rand_left", exp_q.size(), 0);
        check("rand_pops", pops, 1000);

        // Reset while streaming; the refilled FIFO delivers 0x10 first.
        ready = 1'b1;
        for (int i = 1; i <= 8; i++) put(W'(i));
        do_reset(2);
        pops = 0;
        put(8'h10);
        drain(20);
        check("post_rst_pops", pops, 1);
        check("post_rst_first", int'(last_pop), 8'h10);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
